// File: rtl/onehot_req_serializer.sv
// Collects request pulses into a pending set and offers them one at a time
// as a strictly one-hot word over a valid/ready handshake.
module onehot_req_serializer #(
   parameter int N           = 8,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_in,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [N-1:0] out_onehot,
   output logic [N-1:0] pending,
   output logic         busy,
   output logic         overflow
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   // Handshake: a word transfers on any rising edge where out_valid and
   // out_ready are both high; out_onehot is held stable until that edge.
   typedef enum logic {IDLE, OFFER} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [N-1:0]   onehot_q, onehot_d;
   logic [N-1:0]   sel_onehot, load_mask;
   logic [PW-1:0]  ptr_q, ptr_d, sel_idx;
   logic           sel_found, load;
   logic           overflow_q, overflow_d;
   int             idx;

   // Only the registered pending set is searched, so req_in of this cycle
   // cannot be granted before the next edge.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         if (ROUND_ROBIN) idx = (int'(ptr_q) + k) % N;
         else             idx = k;
         if (!sel_found && pending_q[idx]) begin
            sel_found = 1'b1;
            sel_idx   = PW'(idx);
         end
      end
      sel_onehot = sel_found ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;
   end

   always_comb begin
      state_d  = state_q;
      onehot_d = onehot_q;
      load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               load     = 1'b1;
               onehot_d = sel_onehot;
               state_d  = OFFER;
            end
         end
         OFFER: begin
            if (out_ready) begin
               if (sel_found) begin
                  load     = 1'b1;
                  onehot_d = sel_onehot;
               end else begin
                  onehot_d = '0;
                  state_d  = IDLE;
               end
            end
         end
         default: begin
            onehot_d = '0;
            state_d  = IDLE;
         end
      endcase

      load_mask = load ? sel_onehot : '0;
      // A request hitting the bit being loaded re-arms it rather than being lost.
      pending_d  = (pending_q & ~load_mask) | req_in;
      overflow_d = overflow_q | (|(req_in & pending_q & ~load_mask));
      if (load) ptr_d = (sel_idx == PW'(N-1)) ? '0 : sel_idx + 1'b1;
      else      ptr_d = ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         onehot_q   <= '0;
         ptr_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         onehot_q   <= onehot_d;
         ptr_q      <= ptr_d;
         overflow_q <= overflow_d;
      end
   end

   assign out_valid  = (state_q == OFFER);
   assign out_onehot = onehot_q;
   assign pending    = pending_q;
   assign busy       = out_valid | (|pending_q);
   assign overflow   = overflow_q;

endmodule
